// File: rtl/shift_pkg.sv
// Shared constants for the iterative shift/rotate engine: operation modes,
// shift directions and FSM state encodings.
package shift_pkg;

    localparam logic [1:0] MODE_LSH  = 2'b00;
    localparam logic [1:0] MODE_ASH  = 2'b01;
    localparam logic [1:0] MODE_ROT  = 2'b10;
    localparam logic [1:0] MODE_PASS = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_engine_if.sv
// Request/result handshake bundle of the shift engine. The producer/consumer
// side uses the master modport, the engine uses the slave modport.
interface shift_engine_if #(
    parameter int WIDTH = 10,
    parameter int SHW   = $clog2(WIDTH)
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic             in_dir;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, in_dir, in_mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, in_mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/shift_step.sv
// Combinational single-step mover: shifts or rotates the operand by k
// positions (0..STEP) in the requested direction and mode.
module shift_step
    import shift_pkg::*;
#(
    parameter  int WIDTH = 10,
    parameter  int STEP  = 1,
    localparam int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [KW-1:0]    i_k,
    input  logic             i_dir,
    input  logic [1:0]       i_mode,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_data
);

    // One candidate per legal k; each candidate uses a constant shift amount.
    always_comb begin
        o_data = i_data;
        for (int j = 1; j <= STEP; j++) begin
            if (i_k == KW'(j)) begin
                case (i_mode)
                    MODE_ROT: begin
                        if (i_dir == DIR_RIGHT)
                            o_data = (i_data >> j) | (i_data << (WIDTH - j));
                        else
                            o_data = (i_data << j) | (i_data >> (WIDTH - j));
                    end
                    MODE_LSH, MODE_ASH: begin
                        if (i_dir == DIR_RIGHT) begin
                            if ((i_mode == MODE_ASH) && i_sign)
                                o_data = (i_data >> j) | ~({WIDTH{1'b1}} >> j);
                            else
                                o_data = i_data >> j;
                        end else begin
                            o_data = i_data << j;
                        end
                    end
                    default: o_data = i_data;
                endcase
            end
        end
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle barrel shift/rotate engine: moves the captured operand up to
// STEP positions per clock, with valid/ready handshakes on both sides.
module shift_engine
    import shift_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int STEP  = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    shift_engine_if.slave bus
);

    localparam int             KW       = $clog2(STEP + 1);
    localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_outData;
    logic [WIDTH-1:0] w_stepOut;
    logic [SHW-1:0]   r_remaining;
    logic [SHW-1:0]   w_kAmt;
    logic [SHW-1:0]   w_remainingNext;
    logic [KW-1:0]    w_k;
    logic             r_dir;
    logic             r_sign;
    logic [1:0]       r_mode;
    logic             w_inReady;
    logic             w_accept;
    logic             w_immediate;

    assign w_inReady       = (r_state == ST_IDLE) && !rst;
    assign w_accept        = bus.in_valid && w_inReady;
    assign w_immediate     = (bus.in_amt == '0) || (bus.in_mode == MODE_PASS);
    assign w_kAmt          = (r_remaining > STEP_AMT) ? STEP_AMT : r_remaining;
    assign w_k             = KW'(w_kAmt);
    assign w_remainingNext = r_remaining - w_kAmt;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_data (r_data),
        .i_k    (w_k),
        .i_dir  (r_dir),
        .i_mode (r_mode),
        .i_sign (r_sign),
        .o_data (w_stepOut)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_nextState = w_immediate ? ST_DONE : ST_RUN;
            ST_RUN:  if (w_remainingNext == '0) w_nextState = ST_DONE;
            ST_DONE: if (bus.out_ready) w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // The sign bit is frozen at capture so arithmetic fill stays correct
    // even after the original MSB has been shifted away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= '0;
            r_outData   <= '0;
            r_remaining <= '0;
            r_dir       <= DIR_LEFT;
            r_sign      <= 1'b0;
            r_mode      <= MODE_LSH;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data      <= bus.in_data;
                        r_dir       <= bus.in_dir;
                        r_mode      <= bus.in_mode;
                        r_sign      <= bus.in_data[WIDTH-1];
                        r_remaining <= w_immediate ? '0 : bus.in_amt;
                        if (w_immediate)
                            r_outData <= bus.in_data;
                    end
                end
                ST_RUN: begin
                    r_data      <= w_stepOut;
                    r_remaining <= w_remainingNext;
                    if (w_remainingNext == '0)
                        r_outData <= w_stepOut;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_data  = r_outData;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule
